reg_bank_ctrl: RTL

//   Parametrised register bank with a sel/wr/ready request interface, byte-lane

---
 rtl/reg_bank_ctrl_if.sv | 26 ++
 rtl/reg_bank_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/reg_bank_ctrl_if.sv
// Request/response bus between a single requester and reg_bank_ctrl.
// The requester drives sel/wr/addr/wdata/wstrb and holds them until accepted;
// the controller returns registered rdata/ready/err.
interface reg_bank_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                      sel;
    logic                      wr;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      ready;
    logic                      err;

    modport master (
        output sel, wr, addr, wdata, wstrb,
        input  rdata, ready, err
    );

    modport slave (
        input  sel, wr, addr, wdata, wstrb,
        output rdata, ready, err
    );
endinterface

// File: rtl/reg_bank_ctrl.sv
// Register bank controller: DEPTH registers of DATA_WIDTH bits with byte-lane
// write strobes, a fixed read latency of RD_LATENCY clocks and a one-cycle err
// pulse for accesses beyond DEPTH. Serves one transaction at a time.
module reg_bank_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 16'h1234,
    parameter int                    RD_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rstn,
    reg_bank_ctrl_if.slave bus
);

    localparam int NLANE = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_rd_idx;
    logic                   r_rd_oor;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_ready;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_in_range;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_idx;

    // A full-size bank makes every address legal, so no comparator is built.
    generate
        if (DEPTH >= (2 ** ADDR_WIDTH)) begin : g_full
            assign w_in_range = 1'b1;
        end else begin : g_partial
            assign w_in_range = (bus.addr < ADDR_WIDTH'(DEPTH));
        end
    endgenerate

    assign w_idx    = bus.addr[IDX_W-1:0];
    assign w_accept = bus.sel && r_ready;
    assign w_wr_en  = w_accept && bus.wr && w_in_range;

    // Register array: lane-masked writes at the accept edge, reset to RESET_VAL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < NLANE; b++) begin
                if (bus.wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered ready/err/rdata; reset aborts a pending read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rd_idx <= '0;
            r_rd_oor <= 1'b0;
            r_rdata  <= '0;
            r_ready  <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.wr) begin
                            // Writes complete at the accept edge; only flag range errors.
                            r_err <= !w_in_range;
                        end else begin
                            r_rd_idx <= w_idx;
                            r_rd_oor <= !w_in_range;
                            r_cnt    <= CNT_W'(RD_LATENCY);
                            r_ready  <= 1'b0;
                            r_state  <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_rdata <= r_rd_oor ? '0 : r_mem[r_rd_idx];
                        r_err   <= r_rd_oor;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;

endmodule
